fp_normalize_round: RTL and testbench



---
 rtl/fp_normalize_round_pkg.sv | 32 +++
 rtl/fp_normalize_round_rne.sv | 62 ++++++
 rtl/fp_normalize_round.sv | 187 ++++++++++++++++++
 tb/tb_fp_normalize_round.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_normalize_round_pkg.sv
// ---------------------------------------------------------------------------
// fp_normalize_round_pkg
//   Shared definitions for the post-adder normalise/round stage:
//   default field widths, guard/round/sticky bit positions inside the
//   extended mantissa, the FSM state encoding and a small helper for the
//   all-ones exponent value used by the overflow clamp.
// ---------------------------------------------------------------------------
package fp_normalize_round_pkg;

  // Default IEEE-754 single-precision field widths
  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;

  // Guard/round/sticky positions at the bottom of the extended mantissa
  localparam int POS_G = 2;
  localparam int POS_R = 1;
  localparam int POS_S = 0;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Biased exponent value reserved for infinity (255 for an 8-bit field)
  function automatic int expAllOnes(input int ew);
    return (1 << ew) - 1;
  endfunction

endpackage

// File: rtl/fp_normalize_round_rne.sv
// ---------------------------------------------------------------------------
// fp_round_rne
//   Combinational round-to-nearest-even on a normalised mantissa.
//   Takes the fraction plus G/R/S bits (hidden bit already known to be 1),
//   increments the fraction when required and bumps the exponent if the
//   increment carries out of the fraction field.
//
//   Ports
//     i_sign       result sign, passed through into the packed word
//     i_exp        signed biased exponent before rounding (EXP_W+2 bits)
//     i_body       {fraction, G, R, S}
//     o_result     packed {sign, exp, fraction} of the rounded value,
//                  meaningful only when neither flag is set
//     o_overflow   rounded exponent reaches the infinity encoding
//     o_underflow  rounded exponent is zero or negative (flush to zero)
// ---------------------------------------------------------------------------
module fp_round_rne
  import fp_normalize_round_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                    i_sign,
  input  logic signed [EXP_W+1:0] i_exp,
  input  logic [MAN_W+2:0]        i_body,
  output logic [EXP_W+MAN_W:0]    o_result,
  output logic                    o_overflow,
  output logic                    o_underflow
);

  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] EXP_TOP  = XW'(expAllOnes(EXP_W));
  localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;

  logic [MAN_W-1:0]     w_frac;
  logic                 w_g;
  logic                 w_r;
  logic                 w_s;
  logic                 w_round_up;
  logic [MAN_W:0]       w_sum;
  logic signed [XW-1:0] w_exp_adj;

  assign w_frac = i_body[MAN_W+2:POS_G+1];
  assign w_g    = i_body[POS_G];
  assign w_r    = i_body[POS_R];
  assign w_s    = i_body[POS_S];

  // Exactly half an ulp rounds toward the even fraction; anything above half
  // (R or S set) always rounds up.
  assign w_round_up = w_g & (w_r | w_s | w_frac[0]);
  assign w_sum      = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_round_up};

  // A carry out of the fraction means 1.111..1 became 10.000..0: the field
  // wraps to zero on its own and the exponent absorbs the extra bit.
  assign w_exp_adj = w_sum[MAN_W] ? (i_exp + EXP_ONE) : i_exp;

  assign o_overflow  = (w_exp_adj >= EXP_TOP);
  assign o_underflow = (w_exp_adj <= EXP_ZERO);
  assign o_result    = {i_sign, w_exp_adj[EXP_W-1:0], w_sum[MAN_W-1:0]};

endmodule

// File: rtl/fp_normalize_round.sv
// ---------------------------------------------------------------------------
// fp_normalize_round
//   Sequential normalise + round stage placed after the float add/sub
//   datapath. Accepts one raw sum at a time, shifts it until the hidden bit
//   is set, rounds to nearest-even, clamps overflow to infinity and
//   underflow (including denormal range) to signed zero, then presents the
//   packed single-precision word until the consumer takes it.
//
//   Ports
//     clk         rising-edge clock
//     rst         asynchronous active-high reset; aborts any operation
//     in_valid    operand valid
//     in_ready    high in IDLE while not in reset
//     in_sign     result sign
//     in_exp      two's-complement biased exponent of the hidden-bit position
//     in_mant     {carry, hidden, fraction, G, R, S}
//     out_valid   result valid
//     out_ready   consumer accepts the result
//     out_result  packed {sign, exp, fraction}
//
//   Build option
//     FP_FAST_NORM_EN  when defined, normalisation finishes in a single cycle
//                      using a leading-zero count and a barrel shift; results
//                      are identical to the default one-bit-per-cycle shifter.
// ---------------------------------------------------------------------------
module fp_normalize_round
  import fp_normalize_round_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_W+1:0]     in_exp,
  input  logic [MAN_W+4:0]     in_mant,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result
);

  localparam int M     = MAN_W + 5;
  localparam int XW    = EXP_W + 2;
  localparam int RW    = 1 + EXP_W + MAN_W;
  localparam int CARRY = M - 1;
  localparam int HID   = M - 2;
  localparam logic signed [XW-1:0] EXP_ONE = XW'(1);

  // The carry bit is folded away at capture, so the working mantissa only
  // keeps hidden bit, fraction and GRS.
  state_t               r_state;
  logic                 r_sign;
  logic signed [XW-1:0] r_exp;
  logic [M-2:0]         r_mant;
  logic [RW-1:0]        r_result;
  logic                 r_out_valid;

  logic [RW-1:0]        w_round_result;
  logic                 w_round_ovf;
  logic                 w_round_unf;

  fp_round_rne #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .i_sign      (r_sign),
    .i_exp       (r_exp),
    .i_body      (r_mant[M-3:0]),
    .o_result    (w_round_result),
    .o_overflow  (w_round_ovf),
    .o_underflow (w_round_unf)
  );

`ifdef FP_FAST_NORM_EN
  localparam int LZW = $clog2(M);

  logic [LZW-1:0]       w_lzc;
  logic signed [XW-1:0] w_lzc_x;

  // Leading-zero count measured from the hidden-bit position. Scanning
  // upward lets the most significant set bit overwrite earlier hits.
  always_comb begin
    w_lzc = LZW'(M - 1);
    for (int i = 0; i < M - 1; i++) begin
      if (r_mant[i]) begin
        w_lzc = LZW'(HID - i);
      end
    end
  end

  assign w_lzc_x = XW'(w_lzc);
`endif

  assign in_ready   = (r_state == IDLE) && !rst;
  assign out_valid  = r_out_valid;
  assign out_result = r_result;

  // Control FSM and datapath registers. A zero operand skips straight to
  // DONE but raises out_valid one cycle later, giving it a latency of one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_mant      <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign <= in_sign;
            if (in_mant == '0) begin
              r_result <= '0;
              r_state  <= DONE;
            end else if (in_mant[CARRY]) begin
              // Shift right once; the bit that falls off joins the sticky.
              r_mant  <= {in_mant[M-1:2], in_mant[1] | in_mant[0]};
              r_exp   <= $signed(in_exp) + EXP_ONE;
              r_state <= NORM;
            end else begin
              r_mant  <= in_mant[M-2:0];
              r_exp   <= $signed(in_exp);
              r_state <= NORM;
            end
          end
        end

        NORM: begin
`ifdef FP_FAST_NORM_EN
          // Shifting by lzc would walk the exponent through 1 before the
          // hidden bit arrives, which the iterative shifter flags as
          // underflow; an already-normalised value is never flagged here.
          if ((w_lzc != '0) && (w_lzc_x >= r_exp)) begin
            r_result    <= {r_sign, {(RW-1){1'b0}}};
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_mant  <= r_mant << w_lzc;
            r_exp   <= r_exp - w_lzc_x;
            r_state <= ROUND;
          end
`else
          if (r_mant[HID]) begin
            r_state <= ROUND;
          end else if (r_exp <= EXP_ONE) begin
            r_result    <= {r_sign, {(RW-1){1'b0}}};
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_mant <= {r_mant[M-3:0], 1'b0};
            r_exp  <= r_exp - EXP_ONE;
          end
`endif
        end

        ROUND: begin
          if (w_round_ovf) begin
            r_result <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          end else if (w_round_unf) begin
            r_result <= {r_sign, {(RW-1){1'b0}}};
          end else begin
            r_result <= w_round_result;
          end
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end

        DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// ---------------------------------------------------------------------------
// tb_fp_normalize_round
//   Self-checking bench for fp_normalize_round: a table of directed vectors
//   with hand-derived results and latencies, hand-written stall and
//   mid-operation reset sequences, and randomised operands compared against
//   an arithmetic reference model.
//   Honours FP_FAST_NORM_EN for the expected latencies.
// ---------------------------------------------------------------------------
module tb_fp_normalize_round;

`ifdef FP_FAST_NORM_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        s;
    int          e;
    logic [27:0] m;
    logic [31:0] res;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  fp_normalize_round dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference: value-level normalise, round-half-even and clamp
  function automatic logic [31:0] refModel(input logic s, input int e,
                                           input longint m, output int lat);
    longint mm  = m;
    int     ee  = e;
    int     k   = 0;
    longint q;
    longint rem;
    if (mm == 0) begin
      lat = 1;
      return 32'h0;
    end
    if (mm >= (longint'(1) << 27)) begin
      mm = (mm >> 1) | (mm & 1);
      ee = ee + 1;
    end
    while (mm < (longint'(1) << 26)) begin
      if (ee <= 1) begin
        lat = FAST ? 1 : k + 1;
        return {s, 31'h0};
      end
      mm = mm * 2;
      ee = ee - 1;
      k  = k + 1;
    end
    lat = FAST ? 2 : k + 2;
    q   = mm / 8;
    rem = mm % 8;
    if (rem > 4 || (rem == 4 && (q % 2) == 1)) q = q + 1;
    if (q >= (longint'(1) << 24)) begin
      q  = q / 2;
      ee = ee + 1;
    end
    if (ee >= 255) return {s, 8'hFF, 23'h0};
    if (ee <= 0) return {s, 31'h0};
    return {s, 8'(ee), 23'(q - (longint'(1) << 23))};
  endfunction

  task automatic addVec(input logic s, input int e, input logic [27:0] m,
                        input logic [31:0] res, input int lat, input string name);
    vec_t v;
    v.s = s; v.e = e; v.m = m; v.res = res; v.lat = lat; v.name = name;
    vecs.push_back(v);
  endtask

  // Wait for in_ready and present one operand; returns just after edge 0
  task automatic launchOp(input logic s, input int e, input logic [27:0] m);
    int cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!in_ready) checkOutput("in_ready timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = 10'(e);
    in_mant  = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the capture edge until out_valid shows up
  task automatic waitValid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) checkOutput("out_valid timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic acceptResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic applyStimulus(input logic s, input int e, input logic [27:0] m,
                               output logic [31:0] res, output int lat);
    launchOp(s, e, m);
    waitValid(lat);
    res = out_result;
    acceptResult();
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    int          glitches;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_result", out_result, 32'h0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("in_ready after reset", 32'(in_ready), 32'd1);

    // Directed table
    addVec(0, 127, 28'h4000000, 32'h3F800000, 2, "one");
    addVec(0, 127, 28'h8000000, 32'h40000000, 2, "carry");
    addVec(0, 127, 28'h0000008, 32'h34000000, FAST ? 2 : 25, "23 shifts");
    addVec(0, 127, 28'h400000C, 32'h3F800002, 2, "tie odd");
    addVec(0, 127, 28'h4000004, 32'h3F800000, 2, "tie even");
    addVec(0, 127, 28'h7FFFFFC, 32'h40000000, 2, "round carry");
    addVec(0, 254, 28'h8000000, 32'h7F800000, 2, "overflow carry");
    addVec(0, 254, 28'h7FFFFFC, 32'h7F800000, 2, "overflow round");
    addVec(0, 254, 28'h7FFFFF8, 32'h7F7FFFFF, 2, "max finite");
    addVec(0, 1,   28'h2000000, 32'h00000000, 1, "underflow norm");
    addVec(1, 0,   28'h4000000, 32'h80000000, 2, "underflow round");
    addVec(0, 1,   28'h4000000, 32'h00800000, 2, "min normal");
    addVec(1, 5,   28'h0000000, 32'h00000000, 1, "zero");
    addVec(1, 130, 28'h4000000, 32'hC1000000, 2, "negative");
    addVec(0, 127, 28'h8000009, 32'h40000001, 2, "carry sticky");
    addVec(0, 3,   28'h0400000, 32'h00000000, FAST ? 1 : 3, "underflow mid");
    addVec(0, 5,   28'h0400000, 32'h00800000, FAST ? 2 : 6, "shift to min");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s, vecs[i].e, vecs[i].m, res, lat);
      checkOutput({vecs[i].name, " result"}, res, vecs[i].res);
      checkOutput({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].lat));
    end

    // Back-pressure: result and in_ready must hold while out_ready is low
    launchOp(0, 127, 28'h400000C);
    waitValid(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall result", out_result, 32'h3F800002);
      checkOutput("stall out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall in_ready", 32'(in_ready), 32'd0);
    end
    acceptResult();
    @(negedge clk);
    checkOutput("post accept out_valid", 32'(out_valid), 32'd0);
    checkOutput("post accept in_ready", 32'(in_ready), 32'd1);

    // Reset while an operation is in flight
    launchOp(0, 127, 28'h0000008);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort in_ready release", 32'(in_ready), 32'd1);
    glitches = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) glitches++;
    end
    checkOutput("abort nothing emitted", 32'(glitches), 32'd0);
    applyStimulus(1, 127, 28'h4000000, res, lat);
    checkOutput("after abort result", res, 32'hBF800000);
    checkOutput("after abort latency", 32'(lat), 32'd2);

    // Randomised operands against the reference model
    for (int n = 0; n < 60; n++) begin
      logic        s;
      int          e;
      int          pos;
      longint      m;
      logic [31:0] exp_res;
      int          exp_lat;
      s   = 1'($urandom_range(0, 1));
      e   = int'($urandom_range(0, 300)) - 20;
      pos = int'($urandom_range(0, 28));
      if (pos == 28) begin
        m = 0;
      end else begin
        m = (longint'($urandom) & ((longint'(1) << (pos + 1)) - 1)) | (longint'(1) << pos);
      end
      exp_res = refModel(s, e, m, exp_lat);
      applyStimulus(s, e, 28'(m), res, lat);
      checkOutput($sformatf("random %0d result", n), res, exp_res);
      checkOutput($sformatf("random %0d latency", n), 32'(lat), 32'(exp_lat));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
